// File: rtl/fb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_ram_arbiter
// Description : Round-robin writer/reader front end and frame-clear sequencer
//               for a single-port, 1-cycle-latency frame-buffer RAM.
// Revision    : 1.0 - initial release
// ============================================================================

module fb_ram_arbiter #(
  parameter int V = 8,
  parameter int S = 76800,
  parameter int A = 20,
  parameter logic [V-1:0] CLEAR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_req_i,
  input  logic [A-1:0] wr_addr_i,
  input  logic [V-1:0] wr_data_i,
  output logic         wr_gnt_o,
  input  logic         rd_req_i,
  input  logic [A-1:0] rd_addr_i,
  output logic         rd_gnt_o,
  output logic         rd_valid_o,
  output logic [V-1:0] rd_data_o,
  input  logic         clear_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         addr_err_o,
  output logic         ram_we_o,
  output logic [A-1:0] ram_addr_o,
  output logic [V-1:0] ram_data_o,
  input  logic [V-1:0] ram_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [A-1:0] c_size      = A'(S);
  localparam logic [A-1:0] c_last_addr = A'(S - 1);

  state_t       r_state;
  logic [A-1:0] r_cnt;
  logic         r_ptr_rd;
  logic         r_busy;
  logic         r_done;
  logic         r_rd_valid;
  logic         r_rd_oor;
  logic [A-1:0] r_addr_hold;

  logic w_arb_en;
  logic w_wr_gnt;
  logic w_rd_gnt;
  logic w_wr_oor;
  logic w_rd_oor;

  // Arbitration only runs in IDLE; a clear request or reset wins the cycle.
  assign w_arb_en = (r_state == ST_IDLE) && !rst_i && !clear_i;
  assign w_wr_gnt = w_arb_en && wr_req_i && (!rd_req_i || !r_ptr_rd);
  assign w_rd_gnt = w_arb_en && rd_req_i && (!wr_req_i || r_ptr_rd);
  assign w_wr_oor = (wr_addr_i >= c_size);
  assign w_rd_oor = (rd_addr_i >= c_size);

  assign wr_gnt_o   = w_wr_gnt;
  assign rd_gnt_o   = w_rd_gnt;
  assign addr_err_o = (w_wr_gnt && w_wr_oor) || (w_rd_gnt && w_rd_oor);
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign rd_valid_o = r_rd_valid;
  // RAM output is already registered; out-of-range reads return zero.
  assign rd_data_o  = (r_rd_valid && !r_rd_oor) ? ram_data_i : '0;

  always_comb begin
    ram_we_o   = 1'b0;
    ram_addr_o = r_addr_hold;
    ram_data_o = wr_data_i;
    if ((r_state == ST_CLEAR) && !rst_i) begin
      ram_we_o   = 1'b1;
      ram_addr_o = r_cnt;
      ram_data_o = CLEAR_VAL;
    end else if (w_wr_gnt) begin
      ram_we_o   = !w_wr_oor;
      ram_addr_o = wr_addr_i;
    end else if (w_rd_gnt) begin
      ram_addr_o = rd_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ptr_rd    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_oor    <= 1'b0;
      r_addr_hold <= '0;
    end else begin
      r_addr_hold <= ram_addr_o;
      r_rd_valid  <= w_rd_gnt;
      r_rd_oor    <= w_rd_gnt && w_rd_oor;
      if (w_wr_gnt) begin
        r_ptr_rd <= 1'b1;
      end else if (w_rd_gnt) begin
        r_ptr_rd <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (clear_i) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_cnt == c_last_addr) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_ram_arbiter
// Description : Scoreboard bench for fb_ram_arbiter with a 16-word RAM model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fb_ram_arbiter;

  localparam int V = 8;
  localparam int S = 16;
  localparam int A = 20;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         wr_req_i = 1'b0;
  logic [A-1:0] wr_addr_i = '0;
  logic [V-1:0] wr_data_i = '0;
  logic         wr_gnt_o;
  logic         rd_req_i = 1'b0;
  logic [A-1:0] rd_addr_i = '0;
  logic         rd_gnt_o;
  logic         rd_valid_o;
  logic [V-1:0] rd_data_o;
  logic         clear_i = 1'b0;
  logic         busy_o;
  logic         done_o;
  logic         addr_err_o;
  logic         ram_we_o;
  logic [A-1:0] ram_addr_o;
  logic [V-1:0] ram_data_o;
  logic [V-1:0] ram_q = '0;
  logic [V-1:0] mem [S] = '{default: 8'h33};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit           wr;
    bit           rd;
    bit           we;
    logic [A-1:0] addr;
    logic [V-1:0] data;
    bit           err;
  } gnt_t;

  gnt_t         gnt_q[$];
  logic [V-1:0] rd_q[$];

  always #5 clk = ~clk;

  fb_ram_arbiter #(.V(V), .S(S), .A(A), .CLEAR_VAL(8'h00)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .clear_i(clear_i), .busy_o(busy_o), .done_o(done_o), .addr_err_o(addr_err_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_q)
  );

  // Single-port RAM model, 1-cycle read latency; junk beyond the last word.
  always @(posedge clk) begin
    if (ram_we_o && (ram_addr_o < 20'd16)) mem[ram_addr_o[3:0]] <= ram_data_o;
    ram_q <= (ram_addr_o < 20'd16) ? mem[ram_addr_o[3:0]] : 8'hEE;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_w(input logic [A-1:0] a, input logic [V-1:0] d);
    gnt_t e;
    e.wr = 1'b1; e.rd = 1'b0; e.we = (a < 20'd16); e.addr = a; e.data = d; e.err = (a >= 20'd16);
    gnt_q.push_back(e);
  endfunction

  function automatic void push_r(input logic [A-1:0] a, input logic [V-1:0] d);
    gnt_t e;
    e.wr = 1'b0; e.rd = 1'b1; e.we = 1'b0; e.addr = a; e.data = '0; e.err = (a >= 20'd16);
    gnt_q.push_back(e);
    rd_q.push_back(d);
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a grant or read data.
  initial begin
    gnt_t         e;
    logic [V-1:0] d;
    forever begin
      @(negedge clk);
      if (wr_gnt_o || rd_gnt_o) begin
        chk("one_grant", 32'(wr_gnt_o && rd_gnt_o), 32'd0);
        if (gnt_q.size() == 0) begin
          chk("unexpected_grant", 32'({wr_gnt_o, rd_gnt_o}), 32'd0);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_kind", 32'({wr_gnt_o, rd_gnt_o}), 32'({e.wr, e.rd}));
          chk("gnt_we", 32'(ram_we_o), 32'(e.we));
          chk("gnt_addr", 32'(ram_addr_o), 32'(e.addr));
          chk("gnt_err", 32'(addr_err_o), 32'(e.err));
          if (e.we) chk("gnt_data", 32'(ram_data_o), 32'(e.data));
        end
      end else if (!busy_o && !rst_i) begin
        chk("idle_we", 32'(ram_we_o), 32'd0);
      end
      if (rd_valid_o) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid_o), 32'd0);
        end else begin
          d = rd_q.pop_front();
          chk("rd_data", 32'(rd_data_o), 32'(d));
        end
      end
    end
  end

  task automatic do_write(input logic [A-1:0] a, input logic [V-1:0] d);
    int n = 0;
    push_w(a, d);
    wr_req_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    do begin @(negedge clk); n++; end while (!wr_gnt_o && n < 100);
    if (n >= 100) chk("wr_gnt_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    wr_req_i = 1'b0;
  endtask

  task automatic do_read(input logic [A-1:0] a, input logic [V-1:0] d);
    int n = 0;
    push_r(a, d);
    rd_req_i = 1'b1; rd_addr_i = a;
    do begin @(negedge clk); n++; end while (!rd_gnt_o && n < 100);
    if (n >= 100) chk("rd_gnt_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    rd_req_i = 1'b0;
  endtask

  // Caller raises clear_i just after an edge; this walks the busy window.
  task automatic run_clear(input int repulse_at, output int n_busy, output int done_at,
                           output int n_we, output bit gnt_busy, output bit gnt_after);
    n_busy = 0; done_at = 0; n_we = 0; gnt_busy = 1'b0; gnt_after = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      clear_i = (k == repulse_at);
      @(negedge clk);
      if (busy_o) begin
        n_busy++;
        if (done_o) done_at = n_busy;
        if (ram_we_o) n_we++;
        if (wr_gnt_o || rd_gnt_o) gnt_busy = 1'b1;
      end else begin
        gnt_after = rd_gnt_o;
        break;
      end
    end
  endtask

  initial begin
    int n_busy, done_at, n_we, n;
    bit gnt_busy, gnt_after, saw_done;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_wr_gnt", 32'(wr_gnt_o), 32'd0);
    chk("rst_rd_gnt", 32'(rd_gnt_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(addr_err_o), 32'd0);
    chk("rst_we", 32'(ram_we_o), 32'd0);
    @(posedge clk); #1;

    // Both requesters held for 6 cycles: W,R,W,R,W,R on address 1.
    for (int i = 0; i < 3; i++) begin push_w(20'd1, 8'h22); push_r(20'd1, 8'h22); end
    wr_req_i = 1'b1; wr_addr_i = 20'd1; wr_data_i = 8'h22;
    rd_req_i = 1'b1; rd_addr_i = 20'd1;
    repeat (6) @(posedge clk);
    #1 wr_req_i = 1'b0; rd_req_i = 1'b0;

    // Write then immediately read the same word.
    do_write(20'd3, 8'hA5);
    do_read(20'd3, 8'hA5);

    // Fill, clear, read back zeros.
    for (int i = 0; i < 16; i++) do_write(20'(i), 8'h11);
    clear_i = 1'b1;
    run_clear(-1, n_busy, done_at, n_we, gnt_busy, gnt_after);
    chk("clr_busy_cycles", 32'(n_busy), 32'd17);
    chk("clr_done_at", 32'(done_at), 32'd17);
    chk("clr_we_cycles", 32'(n_we), 32'd16);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) do_read(20'(i), 8'h00);

    // Clear alongside a pending read, with a re-pulse mid-clear.
    push_r(20'd4, 8'h00);
    rd_req_i = 1'b1; rd_addr_i = 20'd4; clear_i = 1'b1;
    @(negedge clk);
    chk("clr_precedence", 32'(rd_gnt_o), 32'd0);
    run_clear(5, n_busy, done_at, n_we, gnt_busy, gnt_after);
    chk("clr2_busy_cycles", 32'(n_busy), 32'd17);
    chk("clr2_no_gnt_busy", 32'(gnt_busy), 32'd0);
    chk("clr2_gnt_after", 32'(gnt_after), 32'd1);
    @(posedge clk); #1;
    rd_req_i = 1'b0;

    // Out-of-range accesses.
    do_write(20'd20, 8'h7E);
    do_read(20'd20, 8'h00);

    // Reset in the middle of a clear.
    for (int i = 0; i < 16; i++) do_write(20'(i), 8'(8'h40 + i));
    clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    @(posedge clk); #1;
    // Pointer back at WRITE: write must win the first contested cycle.
    push_w(20'd0, 8'h00); push_r(20'd6, 8'h46);
    wr_req_i = 1'b1; wr_addr_i = 20'd0; wr_data_i = 8'h00;
    rd_req_i = 1'b1; rd_addr_i = 20'd6;
    repeat (2) @(posedge clk);
    #1 wr_req_i = 1'b0; rd_req_i = 1'b0;
    for (int i = 0; i < 16; i++) do_read(20'(i), (i < 5) ? 8'h00 : 8'(8'h40 + i));

    n = 0;
    while ((gnt_q.size() != 0 || rd_q.size() != 0) && n < 20) begin @(posedge clk); n++; end
    repeat (2) @(posedge clk);
    chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fb_ram_arbiter.md
Name: fb_ram_arbiter

Overview:
- Controller for the single-port frame-buffer RAM: 8-bit pixels, 76800 words (320x240), 1-cycle read latency, no read while writing.
- Shares the RAM between a pixel writer (capture/processing side) and a pixel reader (display/processing side) using round-robin arbitration.
- Also provides a frame-clear sequencer that fills the whole buffer with a constant.
- Sits directly in front of the RAM and drives all of its inputs.

Parameters:
V, 8, pixel/data width
S, 76800, number of RAM words (valid addresses 0..S-1)
A, 20, address width
CLEAR_VAL, 0, value written to every word during a clear

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
wr_req_i  in  1  writer requests an access; held until wr_gnt_o
wr_addr_i  in  A  write address
wr_data_i  in  V  write data
wr_gnt_o  out  1  write accepted this cycle
rd_req_i  in  1  reader requests an access; held until rd_gnt_o
rd_addr_i  in  A  read address
rd_gnt_o  out  1  read accepted this cycle
rd_valid_o  out  1  rd_data_o valid (cycle after rd_gnt_o)
rd_data_o  out  V  read data
clear_i  in  1  start-clear pulse
busy_o  out  1  clear in progress
done_o  out  1  1-cycle pulse when clear completes
addr_err_o  out  1  1-cycle pulse: granted access had address >= S
ram_we_o  out  1  to RAM we_i
ram_addr_o  out  A  to RAM address_i
ram_data_o  out  V  to RAM data_i
ram_data_i  in  V  from RAM data_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: wr_gnt_o=0, rd_gnt_o=0, rd_valid_o=0, rd_data_o=0, busy_o=0, done_o=0, addr_err_o=0, ram_we_o=0. Priority pointer = WRITE. State = IDLE. Clear counter = 0.
- States:
  - IDLE: arbitrates requests; clear_i=1 -> CLEAR.
  - CLEAR: writes CLEAR_VAL to address cnt, cnt 0..S-1, one word per cycle. On cnt=S-1 -> DONE.
  - DONE: one cycle, done_o=1 -> IDLE.
- Arbitration (IDLE only, combinational within the cycle):
  - Exactly one requester -> that requester is granted.
  - Both requesting -> the one named by the pointer is granted.
  - After any grant the pointer moves to the other requester.
  - At most one grant per cycle. A non-granted request stays pending with no loss.
- clear_i in IDLE has precedence over requests that cycle: no grant is issued and the FSM enters CLEAR next cycle.
- Clear sequencing:
  - Duration: exactly S cycles of ram_we_o=1, then the DONE cycle.
  - busy_o=1 in CLEAR and DONE.
  - clear_i while busy is ignored.
  - No grants while busy. Requests stay pending and are served from the first IDLE cycle after DONE.
- Write grant: same cycle, ram_we_o=1, ram_addr_o=wr_addr_i, ram_data_o=wr_data_i. The RAM updates on that clock edge.
- Read grant:
  - Same cycle, ram_we_o=0, ram_addr_o=rd_addr_i.
  - Next cycle: rd_valid_o=1 and rd_data_o = RAM word.
  - Back-to-back reads yield one valid per cycle.
  - A read granted the cycle after a write to the same address returns the new data.
- Idle cycles (no grant, not clearing): ram_we_o=0, ram_addr_o holds its last value.
- Out-of-range address (>= S):
  - The grant is still issued and addr_err_o pulses in the grant cycle.
  - A write is suppressed (ram_we_o=0).
  - A read gives rd_valid_o next cycle with rd_data_o=0.
- Reset mid-clear aborts the clear: IDLE, busy_o=0, no done_o pulse. Already-cleared words are not restored.
- Reset with a read in flight: rd_valid_o=0 next cycle.

Test Plan:
- S=16, write 0xA5 @3 with no reader -> wr_gnt_o same cycle, ram_we_o=1, addr 3. Then read @3 -> rd_gnt_o, next cycle rd_valid_o=1, rd_data_o=0xA5.
- wr_req_i and rd_req_i held high together for 6 cycles after reset -> grants alternate W,R,W,R,W,R. No cycle has both grants.
- Fill addresses 0..15 with 0x11, then clear_i pulse -> busy_o high for 17 cycles (16 write + DONE), done_o on the 17th, then reads of 0..15 all return 0x00.
- clear_i together with a pending rd_req_i -> no grant during clear; rd_gnt_o on the first cycle after DONE. clear_i re-pulsed mid-clear -> clear duration unchanged.
- Write 0x7E @20 (S=16) -> addr_err_o pulse, ram_we_o=0. Read @20 -> addr_err_o pulse, next cycle rd_valid_o=1, rd_data_o=0x00.
- rst_i asserted at clear cnt=5 -> next cycle busy_o=0, done_o never pulses, addresses 0..4 read 0x00, addresses 5..15 keep their old data, pointer = WRITE.
